// File: rtl/dabus_pack.sv
// Byte-lane strip and packer for the SRIO logical-layer data path.
// Removes the invalid bytes around each beat's run and either packs runs densely or passes them per beat.
module dabus_pack #(
  parameter int BYTES = 8,
  parameter int DW    = BYTES * 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pack_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic [BYTES-1:0] s_be,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [BYTES-1:0] m_be,
  output logic             m_last,
  output logic             dbg_state
);

  localparam int CW = $clog2(BYTES) + 1;

  localparam logic [0:0] ST_ACC   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Handshake: a beat moves on an edge where s_valid && s_ready; a word moves on an edge where m_valid && m_ready.
  // s_ready depends only on registered state and m_ready, never on s_valid.

  logic [0:0]      state;
  logic [CW-1:0]   r_q;
  logic [DW-1:0]   res_q;
  logic            in_pkt;
  logic            mode_q;

  logic [CW-1:0]   lead;
  logic [CW-1:0]   trail;
  logic [CW-1:0]   n;
  logic            lead_done;
  logic            trail_done;
  logic [DW-1:0]   run_data;
  logic [2*DW-1:0] cat;
  logic [CW-1:0]   total;
  logic [CW-1:0]   rem;
  logic            mode_eff;
  logic            out_free;
  logic            acc;

  function automatic logic [DW-1:0] byte_mask(input logic [CW-1:0] m);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (k < int'(m)) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [BYTES-1:0] be_ones(input logic [CW-1:0] m);
    logic [BYTES-1:0] v;
    v = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (k < int'(m)) v[BYTES-1-k] = 1'b1;
    end
    return v;
  endfunction

  // Run boundaries: enable bit BYTES-1 belongs to byte 0, so leading zeros skip low bytes.
  always_comb begin
    lead       = '0;
    trail      = '0;
    lead_done  = 1'b0;
    trail_done = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (!lead_done) begin
        if (s_be[BYTES-1-i]) lead_done = 1'b1;
        else                 lead      = lead + 1'b1;
      end
      if (!trail_done) begin
        if (s_be[i]) trail_done = 1'b1;
        else         trail      = trail + 1'b1;
      end
    end
    n = (s_be == '0) ? '0 : CW'(BYTES) - lead - trail;
  end

  assign run_data = (s_data >> {lead, 3'b000}) & byte_mask(n);
  assign cat      = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, run_data} << {r_q, 3'b000});
  assign total    = r_q + n;
  assign rem      = total - CW'(BYTES);
  assign mode_eff = in_pkt ? mode_q : pack_en;
  assign out_free = !m_valid || m_ready;
  assign s_ready  = out_free && (state == ST_ACC);
  assign acc      = s_valid && s_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACC;
      r_q     <= '0;
      res_q   <= '0;
      in_pkt  <= 1'b0;
      mode_q  <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_be    <= '0;
      m_last  <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        ST_ACC: begin
          if (acc) begin
            in_pkt <= !s_last;
            if (!in_pkt) mode_q <= pack_en;
            if (!mode_eff) begin
              if (n != '0 || s_last) begin
                m_valid <= 1'b1;
                m_data  <= run_data;
                m_be    <= be_ones(n);
                m_last  <= s_last;
              end
            end else if (total < CW'(BYTES)) begin
              if (s_last) begin
                m_valid <= 1'b1;
                m_data  <= cat[DW-1:0];
                m_be    <= be_ones(total);
                m_last  <= 1'b1;
                r_q     <= '0;
                res_q   <= '0;
              end else begin
                r_q   <= total;
                res_q <= cat[DW-1:0];
              end
            end else begin
              m_valid <= 1'b1;
              m_data  <= cat[DW-1:0];
              m_be    <= '1;
              m_last  <= s_last && (rem == '0);
              r_q     <= rem;
              res_q   <= cat[2*DW-1:DW];
              // Leftover bytes of a last beat need one more word after this one.
              if (s_last && rem != '0) state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (out_free) begin
            m_valid <= 1'b1;
            m_data  <= res_q;
            m_be    <= be_ones(r_q);
            m_last  <= 1'b1;
            r_q     <= '0;
            res_q   <= '0;
            state   <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: doc/dabus_pack.md
Name: dabus_pack

Overview:
- Parametrised successor to the combinational byte-lane strip used on the SRIO logical-layer data path.
- Accepts beats with per-byte enables and strips the leading invalid bytes.
- In pack mode, concatenates the valid byte runs of successive beats into dense output words, with ready/valid on both sides and end-of-packet flush.
- In pass mode, reproduces strip-only behaviour per beat, but registered.

Parameters:
- BYTES, 8, bytes per data word (power of 2, 2..16).
- DW, BYTES*8, data width in bits (derived; do not override).

Ports:
- clk  input  1  logic clock.
- rst_n  input  1  asynchronous active-low reset.
- pack_en  input  1  1 = pack mode, 0 = pass mode; sampled at packet start only.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  DW  input data; byte k = s_data[8k+7:8k].
- s_be  input  BYTES  byte enable; s_be[BYTES-1-k] qualifies byte k.
- s_last  input  1  last beat of packet.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DW  output data; valid bytes are packed from byte 0 upward, unused bytes are 0.
- m_be  output  BYTES  output enables, same mapping; always a run of ones from the MSB.
- m_last  output  1  last word of packet.

Behaviour:
- Reset: m_valid, m_last, m_data and m_be = 0; residual count = 0; state = ACC; pack mode latch = 0. Asynchronous assert, synchronous release.
- Valid run of a beat:
  - lead = count of leading zeros of s_be from the MSB; trail = count of trailing zeros.
  - Run = bytes lead .. BYTES-1-trail; n = run length.
  - Interior zero enables inside the run are treated as valid.
  - s_be == 0 gives n = 0.
- Output register: single stage. s_ready = (!m_valid || m_ready) && state == ACC. Latency is 1 clk from the accepting edge to m_valid.
- m_data, m_be and m_last hold stable while m_valid && !m_ready.
- Pass mode:
  - Each accepted beat with n > 0 or s_last produces exactly one word.
  - m_data = s_data >> (8*lead), zero-filled; m_be = s_be << lead; m_last = s_last.
  - No residual is kept.
- Pack mode:
  - A residual buffer holds r bytes, 0 <= r < BYTES, in time order from byte 0.
  - On accept with r + n < BYTES: append the run; r += n; no output unless s_last.
  - If s_last in that case: emit r + n bytes, m_last = 1, r = 0. If r + n == 0, emit m_be = 0, m_data = 0, m_last = 1.
  - On accept with r + n >= BYTES: emit a full word (the residual, then the first BYTES-r run bytes), m_be = all ones.
  - New r = r + n - BYTES, holding the remaining run bytes.
  - If s_last and new r == 0: m_last = 1 on that word.
  - If s_last and new r > 0: m_last = 0 and go to FLUSH.
  - FLUSH: s_ready = 0. When the output register is free, emit the r residual bytes with m_last = 1, set r = 0 and return to ACC. This is at most one extra word per packet.
  - n = 0 beat without s_last: consumed, no output.
- Mode latch: pack_en is captured on the first accepted beat of a packet, i.e. when r == 0 and the previous accepted beat had s_last or this is the first beat since reset. pack_en changes mid-packet are ignored.
- Reset mid-packet: residual discarded, output word dropped, no m_last generated.
- Throughput: 1 beat per clk with m_ready held 1; one bubble per packet only in the FLUSH case.

Test Plan (BYTES=8):
- Pack, single beat: s_data=64'h8877665544332211, s_be=8'b0011_1111, s_last=1 -> next clk m_valid=1, m_data=64'h0000887766554433, m_be=8'b1111_1100, m_last=1.
- Pack, two beats of s_be=8'b0000_1111 with s_data[63:32]=32'h44332211 then 32'h88776655, last on the second -> one word, m_data=64'h8877665544332211, m_be=8'hFF, m_last=1; no output after the first beat.
- Pack, three beats with s_be=8'b0011_1111 (6 bytes each), last on the third (18 bytes) -> two full words with m_be=8'hFF, m_last=0, then a FLUSH word with m_be=8'b1100_0000, m_last=1; s_ready=0 during the FLUSH cycle.
- Backpressure: hold m_ready=0 for 5 clks with a word pending -> m_data, m_be and m_last stable, s_ready=0, no beat lost; the next word follows on the release edge.
- Pass mode: pack_en=0, s_be=8'b0001_1111, s_data=64'h8877665544332211 -> m_data=64'h0000008877665544, m_be=8'b1111_1000, one word per beat, m_last=s_last.
- Reset asserted with r=5 -> all outputs 0 immediately. After release, a single beat with s_be=8'hFF and s_last gives m_data equal to s_data unmodified: no stale bytes, m_be=8'hFF.
